seven_seg_scan: RTL and testbench

//   Downstream display stage for the stopwatch core.

---
 rtl/seven_seg_scan.sv | 108 ++++++++++
 tb/tb_seven_seg_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode 7-segment scanner for the stopwatch display.
// Multiplexes min/sec BCD digits and blinks the selected pair in adjust mode.
module seven_seg_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] min1,
  input  logic [3:0] min2,
  input  logic [2:0] sec1,
  input  logic [3:0] sec2,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic          blank;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    tick      = (div_cnt_q == DW'(SCAN_DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    // Blink state only runs while adjusting, so each adjust session starts visible.
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!adj) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    case (idx_q)
      2'd0:    digit = sec2;
      2'd1:    digit = {1'b0, sec1};
      2'd2:    digit = min2;
      default: digit = {1'b0, min1};
    endcase

    // idx 2,3 are the minutes pair, idx 0,1 the seconds pair.
    blank = adj & blink_ph_q & (sel ? ~idx_q[1] : idx_q[1]);
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : decode(digit);
    dp_d  = ~(idx_q == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios plus random digits/mode changes,
// checked against a cycle-count based reference of the display behaviour.
module tb_seven_seg_scan;

  localparam int SD = 4;
  localparam int BT = 2;

  logic       clk;
  logic       reset;
  logic [2:0] min1, sec1;
  logic [3:0] min2, sec2;
  logic       adj, sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;
  int cyc = 0;        // active edges since reset release
  int adj_ticks = 0;  // scan ticks seen during the current adjust session

  seven_seg_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .reset(reset),
    .min1(min1), .min2(min2), .sec1(sec1), .sec2(sec2),
    .adj(adj), .sel(sel),
    .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ref_decode(input int v);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 9) return 7'h7F;
    return tbl[v];
  endfunction

  function automatic int model_idx();
    return (cyc / SD) % 4;
  endfunction

  function automatic int model_ph();
    return (adj_ticks / BT) % 2;
  endfunction

  task automatic check3(input string tag, input logic [3:0] ea, input logic [6:0] es,
                        input logic ed);
    tests++;
    assert (an === ea) else begin
      fails++;
      $error("FAIL %s an: observed %b expected %b", tag, an, ea);
    end
    tests++;
    assert (seg === es) else begin
      fails++;
      $error("FAIL %s seg: observed %b expected %b", tag, seg, es);
    end
    tests++;
    assert (dp === ed) else begin
      fails++;
      $error("FAIL %s dp: observed %b expected %b", tag, dp, ed);
    end
  endtask

  // One clock: predict the registered outputs from pre-edge state and inputs.
  task automatic step(input string tag);
    int i, d, p;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    logic blank;
    @(posedge clk);
    i = model_idx();
    p = model_ph();
    case (i)
      0: d = int'(sec2);
      1: d = int'(sec1);
      2: d = int'(min2);
      default: d = int'(min1);
    endcase
    blank = adj && (p == 1) && (sel ? (i < 2) : (i >= 2));
    ea = ~(4'b0001 << i);
    es = blank ? 7'h7F : ref_decode(d);
    ed = (i == 2) ? 1'b0 : 1'b1;
    if (!adj) adj_ticks = 0;
    else if (cyc % SD == SD - 1) adj_ticks++;
    cyc++;
    #1;
    check3(tag, ea, es, ed);
  endtask

  task automatic set_digits(input int m1, input int m2, input int s1, input int s2);
    min1 = 3'(m1); min2 = 4'(m2); sec1 = 3'(s1); sec2 = 4'(s2);
  endtask

  initial begin
    reset = 1'b0;
    adj = 1'b0; sel = 1'b0;
    set_digits(0, 0, 0, 0);

    // Reset held for 3 clocks: everything dark.
    repeat (3) begin
      @(posedge clk); #1;
      check3("reset_hold", 4'b1111, 7'h7F, 1'b1);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc = 0; adj_ticks = 0;
    set_digits(1, 2, 3, 4);
    repeat (16) step("digits_1234");

    set_digits(0, 0, 0, 11);
    repeat (16) step("blank_code");

    set_digits(5, 9, 5, 9);
    adj = 1'b1; sel = 1'b0;
    repeat (32) step("blink_min");
    adj = 1'b0;
    repeat (4) step("adj_off");

    adj = 1'b1; sel = 1'b0;
    for (int k = 0; k < 32 && model_ph() == 0; k++) step("wait_ph");
    step("blank_ph_min");
    sel = 1'b1;
    repeat (16) step("sel_switch");

    // Asynchronous reset in the middle of the idx 2 slot.
    adj = 1'b0;
    for (int k = 0; k < 20 && model_idx() != 2; k++) step("seek_idx2");
    step("in_idx2");
    #2 reset = 1'b0;
    #1;
    check3("async_reset", 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0; adj_ticks = 0;
    set_digits(2, 7, 4, 8);
    repeat (8) step("after_reset");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        set_digits($urandom_range(0, 7), $urandom_range(0, 15),
                   $urandom_range(0, 7), $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) adj = ~adj;
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
